jump_field_encoder: RTL and testbench

JUMP_FIELD_ENCODER -- requirements
Module: jump_field_encoder

---
 rtl/jump_field_encoder_pkg.sv | 16 +
 rtl/result_fifo2.sv | 51 +++++
 rtl/jump_field_encoder.sv | 62 ++++++
 tb/tb_jump_field_encoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/jump_field_encoder_pkg.sv
// Shared MIPS constants and the result record carried through the jump encoder FIFO.
package jump_field_encoder_pkg;

  localparam logic [5:0]  OPC_J      = 6'b000010;
  localparam logic [5:0]  OPC_JAL    = 6'b000011;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam int          RES_W      = 60;

  typedef struct packed {
    logic [31:0] instr;
    logic [25:0] index;
    logic [1:0]  err;
  } enc_result_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry result FIFO; an entry pushed into an empty FIFO is visible right after the push edge.
module result_fifo2
  import jump_field_encoder_pkg::*;
#(
  parameter int DATA_W = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  assign push_ready = (count < 2'(FIFO_DEPTH));
  assign pop_valid  = (count != 2'd0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  // Storage is never cleared, so the head is masked to zero whenever the FIFO is empty.
  assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/jump_field_encoder.sv
// Encodes J/JAL instruction words from a jump target, flags alignment/region errors, queues results.
module jump_field_encoder
  import jump_field_encoder_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic [31:0] Target_addr,
  input  logic [31:0] Pc_plus4,
  input  logic        Link,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic [31:0] Instr_out,
  output logic [25:0] Index_out,
  output logic [1:0]  Err_out,
  output logic [15:0] Enc_count
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  enc_result_t enc;
  enc_result_t head;
  logic        accept;

  always_comb begin
    enc       = '0;
    enc.index = Target_addr[27:2];
    enc.err   = {Target_addr[31:28] != Pc_plus4[31:28], Target_addr[1:0] != 2'b00};
    enc.instr = (enc.err != 2'b00) ? NOP_WORD
                                   : {(Link ? OPC_JAL : OPC_J), Target_addr[27:2]};
  end

  assign accept = In_valid && In_ready;

  // Encode result enters the FIFO on the accepting edge
  result_fifo2 #(.DATA_W(RES_W)) u_fifo (
    .clk        (Clk),
    .rst        (Rst),
    .push_valid (In_valid),
    .push_ready (In_ready),
    .push_data  (enc),
    .pop_valid  (Out_valid),
    .pop_ready  (Out_ready),
    .pop_data   (head)
  );

  assign Instr_out = head.instr;
  assign Index_out = head.index;
  assign Err_out   = head.err;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Enc_count <= 16'd0;
    end else if (accept && (enc.err == 2'b00)) begin
      Enc_count <= sat_inc(Enc_count);
    end
  end

endmodule

// File: tb/tb_jump_field_encoder.sv
// Self-checking bench for jump_field_encoder: directed cases, backpressure, mid-run reset, random traffic.
module tb_jump_field_encoder;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        In_valid;
  logic        In_ready;
  logic [31:0] Target_addr;
  logic [31:0] Pc_plus4;
  logic        Link;
  logic        Out_valid;
  logic        Out_ready;
  logic [31:0] Instr_out;
  logic [25:0] Index_out;
  logic [1:0]  Err_out;
  logic [15:0] Enc_count;

  typedef struct packed {
    logic [31:0] instr;
    logic [25:0] idx;
    logic [1:0]  err;
  } res_t;

  res_t mq[$];
  int   enc_model;
  int   checks = 0;
  int   errors = 0;

  jump_field_encoder dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .In_valid    (In_valid),
    .In_ready    (In_ready),
    .Target_addr (Target_addr),
    .Pc_plus4    (Pc_plus4),
    .Link        (Link),
    .Out_valid   (Out_valid),
    .Out_ready   (Out_ready),
    .Instr_out   (Instr_out),
    .Index_out   (Index_out),
    .Err_out     (Err_out),
    .Enc_count   (Enc_count)
  );

  always #5 Clk = ~Clk;

  function automatic res_t ref_encode(input logic [31:0] t, input logic [31:0] p, input logic l);
    res_t r;
    int unsigned opc;
    r.idx    = 26'((t / 4) % (1 << 26));
    r.err[0] = (t % 4) != 0;
    r.err[1] = (t >> 28) != (p >> 28);
    opc      = l ? 3 : 2;
    r.instr  = (r.err != 0) ? 32'd0 : ((opc << 26) + r.idx);
    return r;
  endfunction

  // Advance one clock and apply the handshake rules to the reference queue.
  task automatic model_edge();
    bit   acc;
    bit   pop;
    res_t e;
    acc = In_valid && (mq.size() < 2);
    pop = (mq.size() > 0) && Out_ready;
    e   = ref_encode(Target_addr, Pc_plus4, Link);
    @(posedge Clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(e);
      if (e.err == 0 && enc_model < 65535) enc_model++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; In_valid = 1'b0; Out_ready = 1'b0; Link = 1'b0;
    Target_addr = '0; Pc_plus4 = '0;
    mq.delete(); enc_model = 0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (Out_valid !== 1'b0 || In_ready !== 1'b1 || Enc_count !== 16'd0 ||
        Instr_out !== 32'd0 || Index_out !== 26'd0 || Err_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b cnt=%h instr=%h idx=%h err=%b required 0 1 0 0 0 0",
               Out_valid, In_ready, Enc_count, Instr_out, Index_out, Err_out);
    end
    Rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] tv [4] = '{32'h0040_0020, 32'h0040_0020, 32'h0040_0022, 32'h1000_0000};
    logic        lv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ei [4] = '{32'h0810_0008, 32'h0C10_0008, 32'h0, 32'h0};
    logic [25:0] ex [4] = '{26'h010_0008, 26'h010_0008, 26'h010_0008, 26'h000_0000};
    logic [1:0]  ee [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic [15:0] ec [4] = '{16'd1, 16'd2, 16'd2, 16'd2};
    for (int i = 0; i < 4; i++) begin
      Target_addr = tv[i]; Pc_plus4 = 32'h0040_0004; Link = lv[i];
      In_valid = 1'b1; Out_ready = 1'b0;
      model_edge();
      In_valid = 1'b0;
      checks++;
      if (Out_valid !== 1'b1 || Instr_out !== ei[i] || Index_out !== ex[i] ||
          Err_out !== ee[i] || Enc_count !== ec[i]) begin
        errors++;
        $display("FAIL directed_%0d: valid=%b instr=%h idx=%h err=%b cnt=%0d required 1 %h %h %b %0d",
                 i, Out_valid, Instr_out, Index_out, Err_out, Enc_count, ei[i], ex[i], ee[i], ec[i]);
      end
      Out_ready = 1'b1;
      model_edge();
      Out_ready = 1'b0;
      checks++;
      if (Out_valid !== 1'b0 || Instr_out !== 32'd0 || Err_out !== 2'd0) begin
        errors++;
        $display("FAIL directed_pop_%0d: valid=%b instr=%h err=%b required 0 0 0",
                 i, Out_valid, Instr_out, Err_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3] = '{32'h0040_0100, 32'h0040_0204, 32'h0040_0308};
    Pc_plus4 = 32'h0040_0004; Link = 1'b0; Out_ready = 1'b0; In_valid = 1'b1;
    Target_addr = a[0]; model_edge();
    checks++;
    if (In_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_after_1: got %b required 1", In_ready);
    end
    Target_addr = a[1]; model_edge();
    checks++;
    if (In_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_after_2: got %b required 0", In_ready);
    end
    Target_addr = a[2]; model_edge();
    checks++;
    if (In_ready !== 1'b0 || Index_out !== a[0][27:2] || mq.size() != 2) begin
      errors++; $display("FAIL b2b_third_held: ready=%b idx=%h required 0 %h", In_ready, Index_out, a[0][27:2]);
    end
    Out_ready = 1'b1;
    model_edge();
    checks++;
    if (Out_valid !== 1'b1 || Index_out !== a[1][27:2] || In_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first_pop: valid=%b idx=%h ready=%b required 1 %h 1",
                         Out_valid, Index_out, In_ready, a[1][27:2]);
    end
    model_edge();
    In_valid = 1'b0;
    checks++;
    if (Out_valid !== 1'b1 || Index_out !== a[2][27:2] || Instr_out !== {6'b000010, a[2][27:2]}) begin
      errors++; $display("FAIL b2b_third_accepted: valid=%b idx=%h instr=%h required 1 %h",
                         Out_valid, Index_out, Instr_out, a[2][27:2]);
    end
    model_edge();
    Out_ready = 1'b0;
    checks++;
    if (Out_valid !== 1'b0 || Enc_count !== 16'(enc_model)) begin
      errors++; $display("FAIL b2b_drained: valid=%b cnt=%0d required 0 %0d", Out_valid, Enc_count, enc_model);
    end
  endtask

  task automatic test_reset_mid();
    Pc_plus4 = 32'h0040_0004; Link = 1'b1; Out_ready = 1'b0; In_valid = 1'b1;
    Target_addr = 32'h0040_0400; model_edge();
    Target_addr = 32'h0040_0500; model_edge();
    #2 Rst = 1'b1;
    #1;
    mq.delete(); enc_model = 0;
    checks++;
    if (Out_valid !== 1'b0 || In_ready !== 1'b1 || Enc_count !== 16'd0 || Index_out !== 26'd0) begin
      errors++; $display("FAIL mid_reset: valid=%b ready=%b cnt=%0d idx=%h required 0 1 0 0",
                         Out_valid, In_ready, Enc_count, Index_out);
    end
    In_valid = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_edge();
    checks++;
    if (Out_valid !== 1'b0 || Instr_out !== 32'd0) begin
      errors++; $display("FAIL mid_reset_stale: valid=%b instr=%h required 0 0", Out_valid, Instr_out);
    end
    In_valid = 1'b1; Target_addr = 32'h0040_0600;
    model_edge();
    In_valid = 1'b0;
    checks++;
    if (Out_valid !== 1'b1 || Index_out !== 26'h010_0180 || Enc_count !== 16'd1) begin
      errors++; $display("FAIL post_reset_accept: valid=%b idx=%h cnt=%0d required 1 0100180 1",
                         Out_valid, Index_out, Enc_count);
    end
    Out_ready = 1'b1; model_edge(); Out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic exp_rdy;
    res_t h;
    for (int n = 0; n < 400; n++) begin
      In_valid  = ($urandom_range(0, 3) != 0);
      Out_ready = ($urandom_range(0, 2) != 0);
      Link      = 1'($urandom);
      Pc_plus4  = $urandom;
      Target_addr = $urandom;
      if ($urandom_range(0, 2) != 0) Target_addr[31:28] = Pc_plus4[31:28];
      if ($urandom_range(0, 2) != 0) Target_addr[1:0] = 2'b00;
      exp_rdy = (mq.size() < 2);
      checks++;
      if (In_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_ready_%0d: got %b required %b", n, In_ready, exp_rdy);
      end
      model_edge();
      h = (mq.size() > 0) ? mq[0] : '0;
      checks++;
      if (Out_valid !== (mq.size() > 0) || Instr_out !== h.instr || Index_out !== h.idx ||
          Err_out !== h.err || Enc_count !== 16'(enc_model)) begin
        errors++;
        $display("FAIL rand_out_%0d: valid=%b instr=%h idx=%h err=%b cnt=%0d required %b %h %h %b %0d",
                 n, Out_valid, Instr_out, Index_out, Err_out, Enc_count,
                 (mq.size() > 0), h.instr, h.idx, h.err, enc_model);
      end
    end
    In_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
